// File: rtl/axi_write_slave_if.sv
// Purpose: AXI4 write-channel bundle (AW/W/B) between a write master and axi_write_slave.
// Ports (signals): AWADDR/AWLEN/AWSIZE/AWVALID/AWREADY address channel,
//                  WDATA/WLAST/WVALID/WREADY data channel, BRESP/BVALID/BREADY response.
// Modports: master drives requests and BREADY; slave drives the ready signals and B.
interface axi_write_slave_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [7:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    modport master (
        output AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WLAST, WVALID, BREADY,
        input  AWREADY, WREADY, BRESP, BVALID
    );

    modport slave (
        input  AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WLAST, WVALID, BREADY,
        output AWREADY, WREADY, BRESP, BVALID
    );
endinterface

// File: rtl/axi_write_slave.sv
// Purpose: AXI4 write slave front end (INCR bursts, one outstanding burst). Checks each
//          burst for legality, turns legal beats into single-word memory writes and
//          answers OKAY or SLVERR on B.
// Ports: clk         rising-edge clock
//        ARESET      synchronous active-high reset
//        axi         AW/W/B channels (slave modport)
//        mem_we      one-cycle write strobe per written word
//        mem_addr    memory word address
//        mem_wdata   memory write data
// ADDR_WIDTH must be at least 12 (the 4 KB page offset is taken from AWADDR[11:0]).
module axi_write_slave #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input  logic                         clk,
    input  logic                         ARESET,
    axi_write_slave_if.slave             axi,
    output logic                         mem_we,
    output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_wdata
);
    localparam int unsigned MEM_AW  = $clog2(MEM_DEPTH);
    localparam int unsigned MAXSIZE = $clog2(DATA_WIDTH / 8);
    localparam int unsigned BYTES   = DATA_WIDTH / 8;
    localparam int unsigned BASE_W  = ADDR_WIDTH - MAXSIZE;
    // Wide enough for address + 256 full-width beats without overflow
    localparam int unsigned SUM_W   = ADDR_WIDTH + MAXSIZE + 10;

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;

    state_e                state_q, state_d;
    logic [BASE_W-1:0]     base_q, base_d;
    logic [7:0]            len_q, len_d;
    logic                  err_q, err_d;
    logic [8:0]            beat_q, beat_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  bvalid_q, bvalid_d;
    logic                  mem_we_q, mem_we_d;
    logic [MEM_AW-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic             aw_hs, w_hs, b_hs, aw_err, misaligned;
    logic [SUM_W-1:0] burst_bytes, end_addr, page_end;

    assign aw_hs = axi.AWVALID && (state_q == IDLE);
    assign w_hs  = axi.WVALID && (state_q == DATA);
    assign b_hs  = axi.BREADY && bvalid_q;

    // Legality of the burst presented on AW
    always_comb begin
        burst_bytes = SUM_W'({1'b0, axi.AWLEN} + 9'd1) << MAXSIZE;
        end_addr    = SUM_W'(axi.AWADDR) + burst_bytes;
        page_end    = SUM_W'(axi.AWADDR[11:0]) + burst_bytes;
        misaligned  = (axi.AWADDR & ADDR_WIDTH'(BYTES - 1)) != '0;
        aw_err      = (axi.AWSIZE != 3'(MAXSIZE)) || misaligned
                    || (end_addr > SUM_W'(MEM_DEPTH * BYTES))
                    || (page_end > SUM_W'(4096));
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (ARESET) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            err_q       <= 1'b0;
            beat_q      <= '0;
            bresp_q     <= 2'b00;
            bvalid_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            err_q       <= err_d;
            beat_q      <= beat_d;
            bresp_q     <= bresp_d;
            bvalid_q    <= bvalid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (aw_hs) state_d = DATA;
            DATA:    if (w_hs && axi.WLAST) state_d = RESP;
            RESP:    if (b_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        axi.AWREADY = (state_q == IDLE);
        axi.WREADY  = (state_q == DATA);
        base_d      = base_q;
        len_d       = len_q;
        err_d       = err_q;
        beat_d      = beat_q;
        bresp_d     = bresp_q;
        bvalid_d    = bvalid_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    base_d = BASE_W'(axi.AWADDR >> MAXSIZE);
                    len_d  = axi.AWLEN;
                    err_d  = aw_err;
                    beat_d = '0;
                end
            end
            DATA: begin
                if (w_hs) begin
                    // Beats past AWLEN are accepted but dropped
                    if (!err_q && (beat_q <= {1'b0, len_q})) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = MEM_AW'(base_q + BASE_W'(beat_q));
                        mem_wdata_d = axi.WDATA;
                    end
                    beat_d = (beat_q == 9'h1FF) ? beat_q : beat_q + 9'd1;
                    if (axi.WLAST) begin
                        bvalid_d = 1'b1;
                        bresp_d  = (err_q || (beat_q != {1'b0, len_q})) ? 2'b10 : 2'b00;
                    end
                end
            end
            RESP: begin
                if (b_hs) bvalid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign axi.BRESP  = bresp_q;
    assign axi.BVALID = bvalid_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_axi_write_slave.sv
// Purpose: self-checking bench for axi_write_slave: directed bursts for the documented
//          corner cases followed by randomized bursts, all checked against a burst-level
//          reference model (legality rules, expected writes and response).
// Ports: none (top level).
module tb_axi_write_slave;
    localparam int unsigned DW        = 32;
    localparam int unsigned AW        = 16;
    localparam int unsigned DEPTH     = 1024;
    localparam int          BYTES     = DW / 8;
    localparam int          MEM_BYTES = DEPTH * BYTES;

    logic        clk;
    logic        areset;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;

    int checks   = 0;
    int failures = 0;
    int we_count = 0;

    axi_write_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    axi_write_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .ARESET    (areset),
        .axi       (bus),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts write strobes seen during the cycle that just ended
    always @(posedge clk) if (mem_we === 1'b1) we_count++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    // One burst: AW handshake, nbeats W beats (WLAST on the last), B handshake after
    // bdelay stall cycles. abort_at >= 0 asserts reset during that beat instead.
    task automatic run_burst(input logic [15:0] addr, input int len, input int size,
                             input int nbeats, input int max_gap, input int bdelay,
                             input int abort_at, input bit fixed_data, input string tag);
        bit          exp_err;
        int          a, nexp, to, gap, we_base;
        logic [1:0]  exp_resp;
        logic [31:0] d;

        a        = int'(addr);
        exp_err  = (size != 2) || (a % BYTES != 0) || (a + (len + 1) * BYTES > MEM_BYTES)
                 || ((a % 4096) + (len + 1) * BYTES > 4096);
        nexp     = exp_err ? 0 : ((nbeats < len + 1) ? nbeats : len + 1);
        exp_resp = (exp_err || nbeats != len + 1) ? 2'b10 : 2'b00;

        @(negedge clk);
        bus.AWADDR  = addr;
        bus.AWLEN   = 8'(len);
        bus.AWSIZE  = 3'(size);
        bus.AWVALID = 1'b1;
        to = 0;
        while (bus.AWREADY !== 1'b1 && to < 50) begin
            @(negedge clk);
            to++;
        end
        chk({tag, "_awready"}, 64'(bus.AWREADY), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.AWVALID = 1'b0;
        chk({tag, "_wready_latency"}, 64'(bus.WREADY), 64'd1);
        chk({tag, "_awready_low"}, 64'(bus.AWREADY), 64'd0);
        we_base = we_count;

        for (int b = 0; b < nbeats; b++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gap; g++) begin
                bus.WVALID = 1'b0;
                @(negedge clk);
            end
            d          = fixed_data ? 32'hA0 + 32'(b) : $urandom;
            bus.WDATA  = d;
            bus.WLAST  = (b == nbeats - 1);
            bus.WVALID = 1'b1;
            if (b == abort_at) begin
                areset = 1'b1;
                @(posedge clk);
                @(negedge clk);
                areset     = 1'b0;
                bus.WVALID = 1'b0;
                bus.WLAST  = 1'b0;
                chk({tag, "_rst_awready"}, 64'(bus.AWREADY), 64'd1);
                chk({tag, "_rst_wready"}, 64'(bus.WREADY), 64'd0);
                chk({tag, "_rst_bvalid"}, 64'(bus.BVALID), 64'd0);
                chk({tag, "_rst_bresp"}, 64'(bus.BRESP), 64'd0);
                chk({tag, "_rst_mem_we"}, 64'(mem_we), 64'd0);
                chk({tag, "_rst_mem_addr"}, 64'(mem_addr), 64'd0);
                chk({tag, "_rst_mem_wdata"}, 64'(mem_wdata), 64'd0);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk({tag, "_post_rst_we"}, 64'(mem_we), 64'd0);
                    chk({tag, "_post_rst_bvalid"}, 64'(bus.BVALID), 64'd0);
                end
                chk({tag, "_abort_writes"}, 64'(we_count - we_base), 64'(nexp < b ? nexp : b));
                return;
            end
            to = 0;
            while (bus.WREADY !== 1'b1 && to < 50) begin
                @(negedge clk);
                to++;
            end
            chk({tag, "_wready"}, 64'(bus.WREADY), 64'd1);
            @(posedge clk);
            @(negedge clk);
            bus.WVALID = 1'b0;
            bus.WLAST  = 1'b0;
            if (!exp_err && b <= len) begin
                chk({tag, "_mem_we"}, 64'(mem_we), 64'd1);
                chk({tag, "_mem_addr"}, 64'(mem_addr), 64'((a / BYTES + b) % DEPTH));
                chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(d));
            end else begin
                chk({tag, "_mem_we_off"}, 64'(mem_we), 64'd0);
            end
        end

        chk({tag, "_bvalid"}, 64'(bus.BVALID), 64'd1);
        chk({tag, "_bresp"}, 64'(bus.BRESP), 64'(exp_resp));
        chk({tag, "_wready_resp"}, 64'(bus.WREADY), 64'd0);
        for (int i = 0; i < bdelay; i++) begin
            @(negedge clk);
            chk({tag, "_stall_bvalid"}, 64'(bus.BVALID), 64'd1);
            chk({tag, "_stall_bresp"}, 64'(bus.BRESP), 64'(exp_resp));
            chk({tag, "_stall_awready"}, 64'(bus.AWREADY), 64'd0);
        end
        bus.BREADY = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.BREADY = 1'b0;
        chk({tag, "_bvalid_drop"}, 64'(bus.BVALID), 64'd0);
        chk({tag, "_awready_back"}, 64'(bus.AWREADY), 64'd1);
        chk({tag, "_write_count"}, 64'(we_count - we_base), 64'(nexp));
    endtask

    initial begin
        int          r, len, nb, sz, word;
        logic [15:0] addr;

        areset      = 1'b1;
        bus.AWADDR  = '0;
        bus.AWLEN   = '0;
        bus.AWSIZE  = '0;
        bus.AWVALID = 1'b0;
        bus.WDATA   = '0;
        bus.WLAST   = 1'b0;
        bus.WVALID  = 1'b0;
        bus.BREADY  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_awready", 64'(bus.AWREADY), 64'd1);
        chk("reset_wready", 64'(bus.WREADY), 64'd0);
        chk("reset_bvalid", 64'(bus.BVALID), 64'd0);
        chk("reset_bresp", 64'(bus.BRESP), 64'd0);
        chk("reset_mem_we", 64'(mem_we), 64'd0);
        chk("reset_mem_addr", 64'(mem_addr), 64'd0);
        chk("reset_mem_wdata", 64'(mem_wdata), 64'd0);
        areset = 1'b0;

        run_burst(16'h0010, 3, 2, 4, 0, 0, -1, 1'b1, "basic");
        run_burst(16'h0000, 0, 1, 1, 0, 0, -1, 1'b0, "narrow");
        run_burst(16'h0FF8, 3, 2, 4, 0, 0, -1, 1'b0, "cross4k");
        run_burst(16'h0FFC, 3, 2, 4, 0, 0, -1, 1'b0, "range");
        run_burst(16'h0100, 3, 2, 2, 0, 0, -1, 1'b0, "early_wlast");
        run_burst(16'h0200, 1, 2, 4, 0, 0, -1, 1'b0, "late_wlast");
        run_burst(16'h0300, 2, 2, 3, 0, 5, -1, 1'b0, "bstall");
        run_burst(16'h0040, 7, 2, 8, 0, 0, 2, 1'b0, "abort");
        run_burst(16'h0040, 7, 2, 8, 1, 1, -1, 1'b0, "after_abort");
        run_burst(16'h0004, 0, 2, 1, 0, 0, -1, 1'b0, "misaligned_ok");
        run_burst(16'h0002, 0, 2, 1, 0, 0, -1, 1'b0, "misaligned");
        run_burst(16'h0FF0, 3, 2, 4, 0, 0, -1, 1'b0, "top_edge");

        for (int n = 0; n < 40; n++) begin
            r    = int'($urandom_range(0, 9));
            len  = int'($urandom_range(0, 7));
            word = int'($urandom_range(0, DEPTH - 1 - len));
            addr = (r == 7) ? 16'($urandom) : 16'(word * BYTES);
            sz   = (r == 9) ? int'($urandom_range(0, 7)) : 2;
            nb   = (r == 8) ? int'($urandom_range(1, len + 3)) : len + 1;
            run_burst(addr, len, sz, nb, 2, int'($urandom_range(0, 3)), -1, 1'b0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
